// File: rtl/ld_st_issue_queue.sv
// In-order load/store issue queue: circular buffer with CDB operand wakeup and
// head-only issue. Optional macro LSQ_HEAD_WAKEUP_BYPASS_EN lets the head issue on a live CDB match.
module ld_st_issue_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             dispatch_valid,
    input  logic             dispatch_opcode,
    input  logic [31:0]      dispatch_rs_data,
    input  logic [31:0]      dispatch_rt_data,
    input  logic [TAG_W-1:0] dispatch_rs_tag,
    input  logic [TAG_W-1:0] dispatch_rt_tag,
    input  logic             dispatch_rs_valid,
    input  logic             dispatch_rt_valid,
    input  logic [31:0]      dispatch_imm,
    input  logic [TAG_W-1:0] dispatch_rd_tag,
    output logic             queue_full,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [31:0]      cdb_data,
    input  logic             issue_ready,
    output logic             issueblk_done,
    output logic             issueque_opcode,
    output logic [31:0]      issueque_rs_data,
    output logic [31:0]      issueque_imm,
    output logic [31:0]      issueque_rt_data,
    output logic [TAG_W-1:0] issueque_rd_tag
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DEPTH-1:0] r_valid;
    logic [DEPTH-1:0] r_op;
    logic [DEPTH-1:0] r_rs_rdy;
    logic [DEPTH-1:0] r_rt_rdy;
    logic [31:0]      r_rs_data [DEPTH];
    logic [31:0]      r_rt_data [DEPTH];
    logic [31:0]      r_imm     [DEPTH];
    logic [TAG_W-1:0] r_rs_tag  [DEPTH];
    logic [TAG_W-1:0] r_rt_tag  [DEPTH];
    logic [TAG_W-1:0] r_rd_tag  [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    logic        w_rs_ok;
    logic        w_rt_ok;
    logic [31:0] w_rs_val;
    logic [31:0] w_rt_val;
    logic        w_head_ready;
    logic        w_issue;
    logic        w_disp;
    logic        w_disp_rs_hit;
    logic        w_disp_rt_hit;

    // Head operand readiness, optionally forwarding a matching CDB broadcast
`ifdef LSQ_HEAD_WAKEUP_BYPASS_EN
    logic w_rs_hit;
    logic w_rt_hit;
    assign w_rs_hit = cdb_valid && (r_rs_tag[r_head] == cdb_tag);
    assign w_rt_hit = cdb_valid && (r_rt_tag[r_head] == cdb_tag);
    assign w_rs_ok  = r_rs_rdy[r_head] || w_rs_hit;
    assign w_rt_ok  = r_rt_rdy[r_head] || w_rt_hit;
    assign w_rs_val = r_rs_rdy[r_head] ? r_rs_data[r_head] : cdb_data;
    assign w_rt_val = r_rt_rdy[r_head] ? r_rt_data[r_head] : cdb_data;
`else
    assign w_rs_ok  = r_rs_rdy[r_head];
    assign w_rt_ok  = r_rt_rdy[r_head];
    assign w_rs_val = r_rs_data[r_head];
    assign w_rt_val = r_rt_data[r_head];
`endif

    assign w_head_ready  = w_rs_ok && (!r_op[r_head] || w_rt_ok);
    assign queue_full    = rst_n && (r_count == CNT_W'(DEPTH));
    assign w_issue       = rst_n && !flush && (r_count != '0) && w_head_ready && issue_ready;
    assign w_disp        = rst_n && !flush && dispatch_valid && !queue_full;
    assign issueblk_done = w_issue;
    assign w_disp_rs_hit = cdb_valid && (cdb_tag == dispatch_rs_tag);
    assign w_disp_rt_hit = cdb_valid && (cdb_tag == dispatch_rt_tag);

    always_comb begin
        issueque_opcode  = 1'b0;
        issueque_rs_data = '0;
        issueque_imm     = '0;
        issueque_rt_data = '0;
        issueque_rd_tag  = '0;
        if (w_issue) begin
            issueque_opcode  = r_op[r_head];
            issueque_rs_data = w_rs_val;
            issueque_imm     = r_imm[r_head];
            issueque_rt_data = w_rt_val;
            issueque_rd_tag  = r_rd_tag[r_head];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_head   <= '0;
            r_tail   <= '0;
            r_count  <= '0;
            r_valid  <= '0;
            r_rs_rdy <= '0;
            r_rt_rdy <= '0;
        end else begin
            // CDB snoop into waiting operands of resident entries
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (r_valid[i] && cdb_valid) begin
                    if (!r_rs_rdy[i] && (r_rs_tag[i] == cdb_tag)) begin
                        r_rs_data[i] <= cdb_data;
                        r_rs_rdy[i]  <= 1'b1;
                    end
                    if (!r_rt_rdy[i] && (r_rt_tag[i] == cdb_tag)) begin
                        r_rt_data[i] <= cdb_data;
                        r_rt_rdy[i]  <= 1'b1;
                    end
                end
            end
            if (w_issue) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + PTR_W'(1);
            end
            if (w_disp) begin
                r_valid[r_tail]   <= 1'b1;
                r_op[r_tail]      <= dispatch_opcode;
                r_imm[r_tail]     <= dispatch_imm;
                r_rd_tag[r_tail]  <= dispatch_rd_tag;
                r_rs_tag[r_tail]  <= dispatch_rs_tag;
                r_rt_tag[r_tail]  <= dispatch_rt_tag;
                r_rs_rdy[r_tail]  <= dispatch_rs_valid || w_disp_rs_hit;
                r_rt_rdy[r_tail]  <= dispatch_rt_valid || w_disp_rt_hit;
                r_rs_data[r_tail] <= (!dispatch_rs_valid && w_disp_rs_hit) ? cdb_data : dispatch_rs_data;
                r_rt_data[r_tail] <= (!dispatch_rt_valid && w_disp_rt_hit) ? cdb_data : dispatch_rt_data;
                r_tail            <= r_tail + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_disp) - CNT_W'(w_issue);
        end
    end

endmodule

// File: tb/tb_ld_st_issue_queue.sv
// Directed bench for ld_st_issue_queue: dispatched entries go into an expected-issue
// queue and are popped/compared whenever the DUT strobes issueblk_done.
module tb_ld_st_issue_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned TAG_W = 6;
`ifdef LSQ_HEAD_WAKEUP_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct packed {
        logic             op;
        logic [31:0]      rs;
        logic [31:0]      imm;
        logic [31:0]      rt;
        logic [TAG_W-1:0] rd;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             dispatch_valid;
    logic             dispatch_opcode;
    logic [31:0]      dispatch_rs_data;
    logic [31:0]      dispatch_rt_data;
    logic [TAG_W-1:0] dispatch_rs_tag;
    logic [TAG_W-1:0] dispatch_rt_tag;
    logic             dispatch_rs_valid;
    logic             dispatch_rt_valid;
    logic [31:0]      dispatch_imm;
    logic [TAG_W-1:0] dispatch_rd_tag;
    logic             queue_full;
    logic             cdb_valid;
    logic [TAG_W-1:0] cdb_tag;
    logic [31:0]      cdb_data;
    logic             issue_ready;
    logic             issueblk_done;
    logic             issueque_opcode;
    logic [31:0]      issueque_rs_data;
    logic [31:0]      issueque_imm;
    logic [31:0]      issueque_rt_data;
    logic [TAG_W-1:0] issueque_rd_tag;

    int   checks = 0;
    int   errors = 0;
    int   mcount = 0;
    exp_t sb[$];
    exp_t pend;

    ld_st_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .dispatch_valid(dispatch_valid), .dispatch_opcode(dispatch_opcode),
        .dispatch_rs_data(dispatch_rs_data), .dispatch_rt_data(dispatch_rt_data),
        .dispatch_rs_tag(dispatch_rs_tag), .dispatch_rt_tag(dispatch_rt_tag),
        .dispatch_rs_valid(dispatch_rs_valid), .dispatch_rt_valid(dispatch_rt_valid),
        .dispatch_imm(dispatch_imm), .dispatch_rd_tag(dispatch_rd_tag),
        .queue_full(queue_full),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .issue_ready(issue_ready), .issueblk_done(issueblk_done),
        .issueque_opcode(issueque_opcode), .issueque_rs_data(issueque_rs_data),
        .issueque_imm(issueque_imm), .issueque_rt_data(issueque_rt_data),
        .issueque_rd_tag(issueque_rd_tag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic disp(input logic op, input logic [31:0] rs, input logic rsv,
                        input logic [TAG_W-1:0] rst, input logic [31:0] rt, input logic rtv,
                        input logic [TAG_W-1:0] rtt, input logic [31:0] imm,
                        input logic [TAG_W-1:0] rd, input logic [31:0] exp_rs,
                        input logic [31:0] exp_rt);
        dispatch_valid    = 1'b1;
        dispatch_opcode   = op;
        dispatch_rs_data  = rs;
        dispatch_rs_valid = rsv;
        dispatch_rs_tag   = rst;
        dispatch_rt_data  = rt;
        dispatch_rt_valid = rtv;
        dispatch_rt_tag   = rtt;
        dispatch_imm      = imm;
        dispatch_rd_tag   = rd;
        pend = '{op: op, rs: exp_rs, imm: imm, rt: exp_rt, rd: rd};
    endtask

    task automatic cdb(input logic [TAG_W-1:0] tag, input logic [31:0] data);
        cdb_valid = 1'b1;
        cdb_tag   = tag;
        cdb_data  = data;
    endtask

    // One cycle: sample at negedge, check against model, update model, advance.
    task automatic tick(input int exp_done);
        bit   acc;
        exp_t e;
        @(negedge clk);
        acc = rst_n && !flush && dispatch_valid && (mcount < int'(DEPTH));
        chk("queue_full", 32'(queue_full), 32'(rst_n && (mcount == int'(DEPTH))));
        if (exp_done >= 0) chk("issueblk_done", 32'(issueblk_done), 32'(exp_done));
        if (issueblk_done === 1'b1) begin
            chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("issue_opcode",  32'(issueque_opcode),  32'(e.op));
                chk("issue_rs_data", issueque_rs_data,      e.rs);
                chk("issue_imm",     issueque_imm,          e.imm);
                chk("issue_rt_data", issueque_rt_data,      e.rt);
                chk("issue_rd_tag",  32'(issueque_rd_tag),  32'(e.rd));
            end
        end else begin
            chk("idle_rs_data", issueque_rs_data, 32'd0);
            chk("idle_rt_data", issueque_rt_data, 32'd0);
            chk("idle_rd_tag",  32'(issueque_rd_tag), 32'd0);
        end
        if (!rst_n || flush) begin
            mcount = 0;
            sb.delete();
        end else begin
            if (acc) sb.push_back(pend);
            mcount = mcount + int'(acc) - int'(issueblk_done);
        end
        @(posedge clk);
        #1;
        dispatch_valid = 1'b0;
        cdb_valid      = 1'b0;
        flush          = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; issue_ready = 1'b0;
        dispatch_valid = 1'b0; dispatch_opcode = 1'b0;
        dispatch_rs_data = '0; dispatch_rt_data = '0; dispatch_imm = '0;
        dispatch_rs_tag = '0; dispatch_rt_tag = '0; dispatch_rd_tag = '0;
        dispatch_rs_valid = 1'b0; dispatch_rt_valid = 1'b0;
        cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
        pend = '0;

        // Reset
        tick(0);
        tick(0);
        rst_n = 1'b1;
        issue_ready = 1'b1;

        // Basic LW issues the cycle after dispatch
        disp(1'b0, 32'h100, 1'b1, 6'd0, 32'h0, 1'b1, 6'd0, 32'h8, 6'd5, 32'h100, 32'h0);
        tick(0);
        tick(1);

        // SW waits on rt tag 9 from CDB
        disp(1'b1, 32'h200, 1'b1, 6'd0, 32'h0, 1'b0, 6'd9, 32'h4, 6'd7, 32'h200, 32'hDEADBEEF);
        tick(0);
        cdb(6'd9, 32'hDEADBEEF);
        tick(BYP ? 1 : 0);
        tick(BYP ? 0 : 1);
        tick(0);

        // Fill to full, 5th dispatch dropped even with a same-cycle issue
        issue_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            disp(1'b0, 32'h1000 + 32'(i), 1'b1, 6'd0, 32'h10 + 32'(i), 1'b1, 6'd0,
                 32'h20 + 32'(i), 6'(i + 20), 32'h1000 + 32'(i), 32'h10 + 32'(i));
            tick(0);
        end
        issue_ready = 1'b1;
        disp(1'b0, 32'h9999, 1'b1, 6'd0, 32'h0, 1'b1, 6'd0, 32'h0, 6'd30, 32'h9999, 32'h0);
        tick(1);
        tick(1);
        tick(1);
        tick(1);
        tick(0);

        // Head blocked on tag 12 holds back a ready younger entry
        disp(1'b0, 32'h0, 1'b0, 6'd12, 32'h0, 1'b1, 6'd0, 32'h30, 6'd11, 32'h55, 32'h0);
        tick(0);
        disp(1'b0, 32'h300, 1'b1, 6'd0, 32'h0, 1'b1, 6'd0, 32'h34, 6'd13, 32'h300, 32'h0);
        tick(0);
        tick(0);
        cdb(6'd12, 32'h55);
        tick(BYP ? 1 : 0);
        tick(1);
        tick(BYP ? 0 : 1);
        tick(0);

        // Same-cycle dispatch wakeup from CDB
        disp(1'b0, 32'h0, 1'b0, 6'd3, 32'h0, 1'b1, 6'd0, 32'h44, 6'd14, 32'h40, 32'h0);
        cdb(6'd3, 32'h40);
        tick(0);
        tick(1);

        // Steady dispatch/issue pairs exercise pointer wrap
        disp(1'b0, 32'h500, 1'b1, 6'd0, 32'h0, 1'b1, 6'd0, 32'h50, 6'd40, 32'h500, 32'h0);
        tick(0);
        for (int i = 1; i < 6; i++) begin
            disp(1'b0, 32'h500 + 32'(i), 1'b1, 6'd0, 32'h0, 1'b1, 6'd0,
                 32'h50 + 32'(i), 6'(40 + i), 32'h500 + 32'(i), 32'h0);
            tick(1);
        end
        tick(1);
        tick(0);

        // Flush with two pending entries; same-cycle dispatch dropped
        issue_ready = 1'b0;
        disp(1'b0, 32'h600, 1'b1, 6'd0, 32'h0, 1'b1, 6'd0, 32'h60, 6'd50, 32'h600, 32'h0);
        tick(0);
        disp(1'b0, 32'h601, 1'b1, 6'd0, 32'h0, 1'b1, 6'd0, 32'h61, 6'd51, 32'h601, 32'h0);
        tick(0);
        issue_ready = 1'b1;
        flush = 1'b1;
        disp(1'b0, 32'h602, 1'b1, 6'd0, 32'h0, 1'b1, 6'd0, 32'h62, 6'd52, 32'h602, 32'h0);
        tick(0);
        tick(0);

        // Reset mid-stream discards entries
        issue_ready = 1'b0;
        disp(1'b0, 32'h700, 1'b1, 6'd0, 32'h0, 1'b1, 6'd0, 32'h70, 6'd60, 32'h700, 32'h0);
        tick(0);
        disp(1'b0, 32'h701, 1'b1, 6'd0, 32'h0, 1'b1, 6'd0, 32'h71, 6'd61, 32'h701, 32'h0);
        tick(0);
        rst_n = 1'b0;
        issue_ready = 1'b1;
        tick(0);
        tick(0);
        rst_n = 1'b1;
        tick(0);
        disp(1'b1, 32'h800, 1'b1, 6'd0, 32'h808, 1'b1, 6'd0, 32'h80, 6'd62, 32'h800, 32'h808);
        tick(0);
        tick(1);
        tick(0);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ld_st_issue_queue.md
LD_ST_ISSUE_QUEUE -- requirements
Module: ld_st_issue_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning queue entries (power of two, at least 2).
REQ-002 SHALL have parameter TAG_W, default 6, meaning ROB/CDB tag width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-005 SHALL have port flush, input, 1, synchronous clear of all entries.
REQ-006 SHALL have port dispatch_valid, input, 1, dispatch request.
REQ-007 SHALL have port dispatch_opcode, input, 1, operation select: 1 = SW, 0 = LW.
REQ-008 SHALL have ports dispatch_rs_data / dispatch_rt_data, input, 32 each, operand values.
REQ-009 SHALL have ports dispatch_rs_tag / dispatch_rt_tag, input, TAG_W each, producer tags.
REQ-010 SHALL have ports dispatch_rs_valid / dispatch_rt_valid, input, 1 each, operand already available.
REQ-011 SHALL have ports dispatch_imm (input, 32, sign-extended offset) and dispatch_rd_tag (input, TAG_W, load destination tag).
REQ-012 SHALL have port queue_full, output, 1, dispatch not accepted.
REQ-013 SHALL have ports cdb_valid (1), cdb_tag (TAG_W) and cdb_data (32), all inputs, broadcast snoop.
REQ-014 SHALL have port issue_ready, input, 1, memory execution unit / CDB slot available.
REQ-015 SHALL have port issueblk_done, output, 1, issue strobe.
REQ-016 SHALL have ports issueque_opcode (1), issueque_rs_data (32), issueque_imm (32), issueque_rt_data (32) and issueque_rd_tag (TAG_W), all outputs, issued entry fields.

Function
REQ-017 SHALL implement a circular buffer with head pointer, tail pointer and count (0..DEPTH), storing the dispatch fields plus per-operand ready bits.
REQ-018 SHALL accept dispatch when dispatch_valid=1 and queue_full=0, writing the entry at tail and advancing tail modulo DEPTH.
REQ-019 SHALL drive queue_full=1 when count==DEPTH; a same-cycle issue SHALL NOT unblock a dispatch.
REQ-020 SHALL, at dispatch, mark an operand ready if its valid bit is 1, or if cdb_valid=1 and cdb_tag equals its tag in the same cycle, capturing cdb_data in the second case.
REQ-021 SHALL, every cycle, capture cdb_data into each valid, not-ready operand whose tag equals cdb_tag when cdb_valid=1, and set its ready bit.
REQ-022 SHALL issue in program order from the head only: head ready = rs ready AND (opcode==0 OR rt ready).
REQ-023 SHALL drive issueblk_done=1 combinationally when count>0, head ready and issue_ready=1; the head is popped on that edge (zero-cycle issue latency from ready).
REQ-024 SHALL drive the issueque_* outputs from the head entry whenever issueblk_done=1, and to 0 otherwise.
REQ-025 SHALL, on simultaneous dispatch and issue with 0<count<DEPTH, leave count unchanged and advance both pointers.
REQ-026 SHALL wrap both pointers from DEPTH-1 to 0.
REQ-027 SHALL, when flush=1, force issueblk_done=0 that cycle and clear count and pointers at the edge; same-cycle dispatch is dropped.

Reset
REQ-028 SHALL, when rst_n=0 at an edge, clear count, head, tail and all entry valid/ready bits; rst_n has priority over flush.
REQ-029 SHALL, during and after reset, output queue_full=0, issueblk_done=0 and all issueque_* outputs 0; entries in flight are discarded.

Configuration
REQ-030 SHALL support macro LSQ_HEAD_WAKEUP_BYPASS_EN.
REQ-031 SHALL, when LSQ_HEAD_WAKEUP_BYPASS_EN is defined, treat a head operand matched by the current CDB broadcast as ready that cycle and drive cdb_data on the corresponding issueque_* output.
REQ-032 SHALL, when LSQ_HEAD_WAKEUP_BYPASS_EN is undefined, make a CDB-woken operand eligible one cycle after capture.

Verification
REQ-033 SHALL cover: reset, then LW dispatch with rs_valid=1, rs=0x100, imm=0x8, rd_tag=5, issue_ready=1 -> next cycle issueblk_done=1, rs=0x100, imm=0x8, opcode=0, rd_tag=5.
REQ-034 SHALL cover: SW with rs ready and rt_tag=9 not ready, then CDB tag 9 data 0xDEADBEEF -> issueque_rt_data=0xDEADBEEF; issue in the same cycle with LSQ_HEAD_WAKEUP_BYPASS_EN defined, the next cycle without it.
REQ-035 SHALL cover: 4 dispatches with issue_ready=0 -> queue_full=1; 5th dispatch ignored; release issue_ready -> 4 in-order issues, then queue_full=0.
REQ-036 SHALL cover: head not ready while the younger entry is ready -> no issue until the head wakes (in-order issue).
REQ-037 SHALL cover: dispatch rs_tag=3 with rs_valid=0 and CDB tag 3 data 0x40 in the same cycle -> entry captures 0x40 and is ready.
REQ-038 SHALL cover: 6 dispatch/issue pairs for pointer wrap, then flush with 2 entries pending and rst_n=0 mid-stream -> issueblk_done=0 and queue empty afterwards.
